mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 1: number of cycles mem_valid is held per access (legal range 1..15).
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port ifu_req_valid, input, 1: fetch request present.
REQ-005 SHALL have port ifu_req_ready, output, 1: fetch request accepted this cycle.
REQ-006 SHALL have port ifu_req_addr, input, 32: fetch address.
REQ-007 SHALL have port ifu_resp_valid, output, 1: fetch data available.
REQ-008 SHALL have port ifu_resp_ready, input, 1: fetch side consumes response.
REQ-009 SHALL have port ifu_resp_data, output, 32: fetched word.
REQ-010 SHALL have port lsu_req_valid, input, 1: load/store request present.
REQ-011 SHALL have port lsu_req_ready, output, 1: load/store request accepted.
REQ-012 SHALL have port lsu_req_wen, input, 1: 1 = store, 0 = load.
REQ-013 SHALL have port lsu_req_addr, input, 32: load/store address.
REQ-014 SHALL have port lsu_req_wdata, input, 32: store data.
REQ-015 SHALL have port lsu_req_wmask, input, 8: store byte mask.
REQ-016 SHALL have port lsu_resp_valid, output, 1: load data or store acknowledge available.
REQ-017 SHALL have port lsu_resp_ready, input, 1: LSU consumes response.
REQ-018 SHALL have port lsu_resp_data, output, 32: load data; 0 for a store.
REQ-019 SHALL have ports mem_valid/mem_wen (output, 1), mem_raddr/mem_waddr/mem_wdata (output, 32), mem_wmask (output, 8), mem_rdata (input, 32), driving the shared DPI memory controller.

Function
REQ-020 SHALL implement states IDLE, ACCESS, RESP; exactly one transaction is outstanding at any time.
REQ-021 In IDLE, the ready signal SHALL be asserted only to the requester selected by arbitration, and only when that requester's valid is high; in ACCESS and RESP, both ready signals SHALL be 0.
REQ-022 A request handshake in cycle N SHALL latch the address, wen, wdata, wmask and owner, and SHALL move the FSM to ACCESS; later changes on the request inputs SHALL be ignored.
REQ-023 Arbitration SHALL be fixed priority, with the LSU winning over the IFU when both are valid in the same IDLE cycle (see REQ-032).
REQ-024 ACCESS SHALL last exactly LATENCY cycles (N+1..N+LATENCY), driving mem_valid=1 and the latched fields; mem_raddr and mem_waddr SHALL both carry the latched address.
REQ-025 An IFU access SHALL always drive mem_wen=0, mem_wdata=0 and mem_wmask=0.
REQ-026 In the last ACCESS cycle, mem_rdata SHALL be registered for a read; for a write, 0 SHALL be registered instead.
REQ-027 In RESP (from N+LATENCY+1), only the owner's resp_valid SHALL be 1, with resp_data held stable until resp_ready is 1; the handshake cycle SHALL return the FSM to IDLE.
REQ-028 Outside ACCESS, all mem_* outputs SHALL be 0, so that no memory read or write side effect occurs.
REQ-029 A store with wmask=0 SHALL still perform a full access and return an acknowledge.
REQ-030 With resp_ready held high, back-to-back grants SHALL be spaced LATENCY+2 cycles apart.

Reset
REQ-031 While rst is high, the FSM SHALL be IDLE, and all ready, resp_valid, resp_data and mem_* outputs SHALL be 0; a transaction in flight SHALL be discarded, with no response and no mem_valid in the cycle after reset.

Configuration
REQ-032 With MEM_ARB_RR_EN defined, arbitration SHALL be round-robin: on conflict, the requester not granted last wins, and after reset the LSU wins the first conflict; without MEM_ARB_RR_EN, REQ-023 fixed priority SHALL apply and no priority state SHALL exist.

Structure
REQ-033 Package mem_arb_pkg SHALL hold the state enum (IDLE/ACCESS/RESP), the owner typedef (OWN_IFU/OWN_LSU), and the constants ADDR_W=32, DATA_W=32, MASK_W=8.
REQ-034 Arbitration SHALL be isolated in a single sub-module, mem_arb_pick, with fixed and round-robin variants selected by MEM_ARB_RR_EN; the latency counter SHALL remain inline.

Verification
REQ-035 Scenario: IFU read of 0x80000000 with mem_rdata=0x00000413 and LATENCY=1 -> mem_valid high for 1 cycle; ifu_resp_data=0x00000413 at cycle N+2.
REQ-036 Scenario: IFU and LSU both valid in the same cycle -> LSU granted first, IFU granted LATENCY+2 cycles later; with MEM_ARB_RR_EN, a second simultaneous conflict grants the IFU.
REQ-037 Scenario: LSU store to 0x80001000, data 0xDEADBEEF, mask 0x0F -> one access with mem_wen=1 and exactly those values; lsu_resp_data=0.
REQ-038 Scenario: LATENCY=3 with lsu_resp_ready held low for 5 cycles -> mem_valid high for exactly 3 cycles; response held stable; ifu_req_ready stays 0 until the LSU response handshake.
REQ-039 Scenario: rst asserted in the second ACCESS cycle -> mem_valid=0 and resp_valid=0 the next cycle; a new IFU request is granted in the first cycle after rst is released.
REQ-040 Scenario: request inputs changed after the handshake -> memory sees only the latched values.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and widths for the IFU/LSU memory arbiter.
//   state_t : arbiter FSM states (IDLE, ACCESS, RESP)
//   owner_t : which requester owns the outstanding transaction
//   ADDR_W / DATA_W / MASK_W : memory interface widths
// Optional build macro: MEM_ARB_RR_EN (round-robin arbitration, see mem_arb_pick)
// ---------------------------------------------------------------------------
package mem_arb_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int MASK_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
// Chooses which requester is offered the memory port in the current IDLE cycle.
//   clk, rst   : clock and synchronous active-high reset (round-robin build only)
//   ifu_valid  : fetch request present
//   lsu_valid  : load/store request present
//   grant      : a handshake happens this cycle (round-robin build only)
//   pick       : selected owner; only meaningful when at least one valid is high
// Build macro MEM_ARB_RR_EN:
//   undefined : fixed priority, LSU beats IFU, no state
//   defined   : round-robin, on conflict the requester not granted last wins;
//               after reset the LSU wins the first conflict
// ---------------------------------------------------------------------------
module mem_arb_pick
   import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
   input  logic   clk,
   input  logic   rst,
   input  logic   grant,
`endif
   input  logic   ifu_valid,
   input  logic   lsu_valid,
   output owner_t pick
);

`ifdef MEM_ARB_RR_EN
   owner_t last_q;
   logic   conflict;

   assign conflict = ifu_valid && lsu_valid;

   always_comb begin
      if (conflict)
         pick = (last_q == OWN_LSU) ? OWN_IFU : OWN_LSU;
      else
         pick = (ifu_valid && !lsu_valid) ? OWN_IFU : OWN_LSU;
   end

   // Reset to "IFU granted last" so the very first conflict goes to the LSU.
   always_ff @(posedge clk) begin
      if (rst)
         last_q <= OWN_IFU;
      else if (grant)
         last_q <= pick;
   end
`else
   assign pick = (ifu_valid && !lsu_valid) ? OWN_IFU : OWN_LSU;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one memory controller port between the instruction fetch unit (IFU)
// and the load/store unit (LSU). One transaction is outstanding at a time:
// IDLE (grant) -> ACCESS (LATENCY cycles, mem_valid=1) -> RESP (until the
// owner's resp_ready) -> IDLE.
// Parameters:
//   LATENCY : cycles mem_valid is held per access, 1..15
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   ifu_req_*  / ifu_resp_*       : fetch request / response channel
//   lsu_req_*  / lsu_resp_*       : load/store request / response channel
//   mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask : to memory
//   mem_rdata                     : read data from memory
// Build macro MEM_ARB_RR_EN selects round-robin arbitration (default: LSU
// has fixed priority over IFU).
// ---------------------------------------------------------------------------
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_req_addr,
   output logic              ifu_resp_valid,
   input  logic              ifu_resp_ready,
   output logic [DATA_W-1:0] ifu_resp_data,

   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic              lsu_req_wen,
   input  logic [ADDR_W-1:0] lsu_req_addr,
   input  logic [DATA_W-1:0] lsu_req_wdata,
   input  logic [MASK_W-1:0] lsu_req_wmask,
   output logic              lsu_resp_valid,
   input  logic              lsu_resp_ready,
   output logic [DATA_W-1:0] lsu_resp_data,

   output logic              mem_valid,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_raddr,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [MASK_W-1:0] mem_wmask,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_t            state;
   owner_t            owner;
   owner_t            pick;
   logic [ADDR_W-1:0] addr_q;
   logic              wen_q;
   logic [DATA_W-1:0] wdata_q;
   logic [MASK_W-1:0] wmask_q;
   logic [DATA_W-1:0] rdata_q;
   logic [3:0]        cnt;

   logic in_idle, in_access, in_resp;
   logic grant, resp_hs;

   // NOTE: state decodes are qualified with !rst so every output is 0 for the
   // whole time rst is high, not just from the first reset edge onwards.
   assign in_idle   = (state == IDLE)   && !rst;
   assign in_access = (state == ACCESS) && !rst;
   assign in_resp   = (state == RESP)   && !rst;

   mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
      .clk       (clk),
      .rst       (rst),
      .grant     (grant),
`endif
      .ifu_valid (ifu_req_valid),
      .lsu_valid (lsu_req_valid),
      .pick      (pick)
   );

   assign ifu_req_ready = in_idle && ifu_req_valid && (pick == OWN_IFU);
   assign lsu_req_ready = in_idle && lsu_req_valid && (pick == OWN_LSU);
   assign grant         = ifu_req_ready || lsu_req_ready;

   assign resp_hs = (owner == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;

   always_ff @(posedge clk) begin
      // NOTE: the few datapath registers are reset as well, so a discarded
      // transaction can never resurface as stale response data.
      if (rst) begin
         state   <= IDLE;
         owner   <= OWN_IFU;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         wmask_q <= '0;
         rdata_q <= '0;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  state <= ACCESS;
                  owner <= pick;
                  cnt   <= 4'(LATENCY - 1);
                  if (pick == OWN_LSU) begin
                     addr_q  <= lsu_req_addr;
                     wen_q   <= lsu_req_wen;
                     wdata_q <= lsu_req_wdata;
                     wmask_q <= lsu_req_wmask;
                  end else begin
                     // Fetches are always plain reads.
                     addr_q  <= ifu_req_addr;
                     wen_q   <= 1'b0;
                     wdata_q <= '0;
                     wmask_q <= '0;
                  end
               end
            end
            ACCESS: begin
               if (cnt == 4'd0) begin
                  // Stores acknowledge with zero data.
                  rdata_q <= wen_q ? '0 : mem_rdata;
                  state   <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (resp_hs)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Memory port is quiet outside ACCESS so no stray read/write side effects.
   assign mem_valid = in_access;
   assign mem_wen   = in_access && wen_q;
   assign mem_raddr = in_access ? addr_q  : '0;
   assign mem_waddr = in_access ? addr_q  : '0;
   assign mem_wdata = in_access ? wdata_q : '0;
   assign mem_wmask = in_access ? wmask_q : '0;

   assign ifu_resp_valid = in_resp && (owner == OWN_IFU);
   assign lsu_resp_valid = in_resp && (owner == OWN_LSU);
   assign ifu_resp_data  = ifu_resp_valid ? rdata_q : '0;
   assign lsu_resp_data  = lsu_resp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. Two instances share the stimulus:
// u_dut1 (LATENCY=1) and u_dut3 (LATENCY=3). Single transactions are driven
// from a vector table; conflict, back-pressure, reset and latching behaviour
// use hand-written sequences. Honors MEM_ARB_RR_EN for the conflict checks.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        ifu_req_valid, ifu_resp_ready;
   logic [31:0] ifu_req_addr;
   logic        lsu_req_valid, lsu_req_wen, lsu_resp_ready;
   logic [31:0] lsu_req_addr, lsu_req_wdata;
   logic [7:0]  lsu_req_wmask;
   logic [31:0] mem_rdata;

   logic        ifu_req_ready1, ifu_resp_valid1, lsu_req_ready1, lsu_resp_valid1;
   logic [31:0] ifu_resp_data1, lsu_resp_data1;
   logic        mem_valid1, mem_wen1;
   logic [31:0] mem_raddr1, mem_waddr1, mem_wdata1;
   logic [7:0]  mem_wmask1;

   logic        ifu_req_ready3, ifu_resp_valid3, lsu_req_ready3, lsu_resp_valid3;
   logic [31:0] ifu_resp_data3, lsu_resp_data3;
   logic        mem_valid3, mem_wen3;
   logic [31:0] mem_raddr3, mem_waddr3, mem_wdata3;
   logic [7:0]  mem_wmask3;

   mem_arbiter #(.LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready1),
      .ifu_req_addr(ifu_req_addr), .ifu_resp_valid(ifu_resp_valid1),
      .ifu_resp_ready(ifu_resp_ready), .ifu_resp_data(ifu_resp_data1),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready1),
      .lsu_req_wen(lsu_req_wen), .lsu_req_addr(lsu_req_addr),
      .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
      .lsu_resp_valid(lsu_resp_valid1), .lsu_resp_ready(lsu_resp_ready),
      .lsu_resp_data(lsu_resp_data1),
      .mem_valid(mem_valid1), .mem_wen(mem_wen1), .mem_raddr(mem_raddr1),
      .mem_waddr(mem_waddr1), .mem_wdata(mem_wdata1), .mem_wmask(mem_wmask1),
      .mem_rdata(mem_rdata)
   );

   mem_arbiter #(.LATENCY(3)) u_dut3 (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready3),
      .ifu_req_addr(ifu_req_addr), .ifu_resp_valid(ifu_resp_valid3),
      .ifu_resp_ready(ifu_resp_ready), .ifu_resp_data(ifu_resp_data3),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready3),
      .lsu_req_wen(lsu_req_wen), .lsu_req_addr(lsu_req_addr),
      .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
      .lsu_resp_valid(lsu_resp_valid3), .lsu_resp_ready(lsu_resp_ready),
      .lsu_resp_data(lsu_resp_data3),
      .mem_valid(mem_valid3), .mem_wen(mem_wen3), .mem_raddr(mem_raddr3),
      .mem_waddr(mem_waddr3), .mem_wdata(mem_wdata3), .mem_wmask(mem_wmask3),
      .mem_rdata(mem_rdata)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        ifu_v;
      logic        lsu_v;
      logic        wen;
      logic [31:0] ifu_addr;
      logic [31:0] lsu_addr;
      logic [31:0] wdata;
      logic [7:0]  wmask;
      logic [31:0] rdata;
      logic        exp_lsu;
      logic [31:0] exp_addr;
      logic        exp_wen;
      logic [31:0] exp_wdata;
      logic [7:0]  exp_wmask;
      logic [31:0] exp_resp;
   } vec_t;

   vec_t vecs[5];

   task automatic clear_inputs();
      ifu_req_valid  = 1'b0;
      ifu_req_addr   = '0;
      ifu_resp_ready = 1'b1;
      lsu_req_valid  = 1'b0;
      lsu_req_wen    = 1'b0;
      lsu_req_addr   = '0;
      lsu_req_wdata  = '0;
      lsu_req_wmask  = '0;
      lsu_resp_ready = 1'b1;
      mem_rdata      = '0;
   endtask

   // Called at a negedge; returns at a negedge with rst low and both DUTs IDLE.
   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // One complete transaction on u_dut1 (LATENCY=1), starting at a negedge in IDLE.
   task automatic run_vec(input int idx, input vec_t v);
      ifu_req_valid = v.ifu_v;
      ifu_req_addr  = v.ifu_addr;
      lsu_req_valid = v.lsu_v;
      lsu_req_wen   = v.wen;
      lsu_req_addr  = v.lsu_addr;
      lsu_req_wdata = v.wdata;
      lsu_req_wmask = v.wmask;
      mem_rdata     = v.rdata;
      #1;
      check($sformatf("v%0d ifu_req_ready", idx), ifu_req_ready1, v.ifu_v && !v.exp_lsu);
      check($sformatf("v%0d lsu_req_ready", idx), lsu_req_ready1, v.exp_lsu);
      @(negedge clk);
      // Scramble the request side: the access must use the latched values.
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      ifu_req_addr  = ~v.ifu_addr;
      lsu_req_addr  = ~v.lsu_addr;
      lsu_req_wdata = ~v.wdata;
      lsu_req_wmask = ~v.wmask;
      lsu_req_wen   = ~v.wen;
      #1;
      check($sformatf("v%0d mem_valid", idx), mem_valid1, 1'b1);
      check($sformatf("v%0d mem_wen", idx), mem_wen1, v.exp_wen);
      check($sformatf("v%0d mem_raddr", idx), mem_raddr1, v.exp_addr);
      check($sformatf("v%0d mem_waddr", idx), mem_waddr1, v.exp_addr);
      check($sformatf("v%0d mem_wdata", idx), mem_wdata1, v.exp_wdata);
      check($sformatf("v%0d mem_wmask", idx), mem_wmask1, v.exp_wmask);
      @(negedge clk);
      mem_rdata = ~v.rdata;
      #1;
      check($sformatf("v%0d mem_valid_resp", idx), mem_valid1, 1'b0);
      check($sformatf("v%0d ifu_resp_valid", idx), ifu_resp_valid1, !v.exp_lsu);
      check($sformatf("v%0d lsu_resp_valid", idx), lsu_resp_valid1, v.exp_lsu);
      check($sformatf("v%0d resp_data", idx),
            v.exp_lsu ? lsu_resp_data1 : ifu_resp_data1, v.exp_resp);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, mv, bad_rdy, bad_resp, bad_mem;

      //                ifu lsu wen ifu_addr      lsu_addr      wdata         wmask  rdata         lsu  addr          wen  wdata         wmask  resp
      vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0,        32'h0,        8'h00, 32'h0000_0413, 1'b0, 32'h8000_0000, 1'b0, 32'h0,        8'h00, 32'h0000_0413};
      vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0,        32'h8000_1000, 32'hDEAD_BEEF, 8'h0F, 32'h1234_5678, 1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 8'h0F, 32'h0};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_0100, 32'h0,        8'h00, 32'hCAFE_F00D, 1'b1, 32'h0000_0100, 1'b0, 32'h0,        8'h00, 32'hCAFE_F00D};
      vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0,        32'h0000_0200, 32'h5555_AAAA, 8'h00, 32'h7777_7777, 1'b1, 32'h0000_0200, 1'b1, 32'h5555_AAAA, 8'h00, 32'h0};
      vecs[4] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0300, 32'hFFFF_FFFF, 8'hFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0,        8'h00, 32'hFFFF_FFFF};

      // Reset state: requests present while rst is high must not be accepted.
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(negedge clk);
      ifu_req_valid = 1'b1;
      lsu_req_valid = 1'b1;
      #1;
      check("rst ifu_req_ready", ifu_req_ready1, 1'b0);
      check("rst lsu_req_ready", lsu_req_ready1, 1'b0);
      check("rst mem_valid", mem_valid1, 1'b0);
      check("rst resp_valid", ifu_resp_valid1 | lsu_resp_valid1, 1'b0);
      check("rst resp_data", ifu_resp_data1 | lsu_resp_data1, 32'h0);

      // Table: single transactions on the LATENCY=1 instance.
      do_reset();
      for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

      // Conflict: LSU first, next IDLE cycle comes LATENCY+2 cycles later.
      do_reset();
      ifu_req_valid = 1'b1;
      ifu_req_addr  = 32'h0000_1000;
      lsu_req_valid = 1'b1;
      lsu_req_addr  = 32'h0000_2000;
      #1;
      check("conflict1 lsu_req_ready", lsu_req_ready1, 1'b1);
      check("conflict1 ifu_req_ready", ifu_req_ready1, 1'b0);
      cyc = 0;
      do begin
         @(negedge clk);
         #1;
         cyc++;
      end while (!(ifu_req_ready1 || lsu_req_ready1) && cyc < 20);
      check("conflict grant spacing", cyc, 3);
`ifdef MEM_ARB_RR_EN
      check("conflict2 ifu_req_ready", ifu_req_ready1, 1'b1);
      check("conflict2 lsu_req_ready", lsu_req_ready1, 1'b0);
`else
      check("conflict2 ifu_req_ready", ifu_req_ready1, 1'b0);
      check("conflict2 lsu_req_ready", lsu_req_ready1, 1'b1);
`endif

      // LATENCY=3 with LSU response back-pressure for 5 cycles.
      @(negedge clk);
      do_reset();
      mem_rdata      = 32'h55AA_55AA;
      lsu_req_valid  = 1'b1;
      lsu_req_addr   = 32'h0000_0040;
      ifu_req_valid  = 1'b1;
      ifu_req_addr   = 32'h0000_0080;
      lsu_resp_ready = 1'b0;
      #1;
      check("bp lsu_req_ready", lsu_req_ready3, 1'b1);
      @(negedge clk);
      lsu_req_valid = 1'b0;
      mv = 0; bad_rdy = 0; bad_resp = 0;
      for (int i = 1; i <= 8; i++) begin
         #1;
         if (mem_valid3) mv++;
         if (ifu_req_ready3) bad_rdy++;
         if (i >= 4) begin
            if (!(lsu_resp_valid3 && lsu_resp_data3 == 32'h55AA_55AA)) bad_resp++;
            mem_rdata = 32'h0BAD_0000 + 32'(i);
         end
         @(negedge clk);
      end
      check("bp mem_valid cycles", mv, 3);
      check("bp ifu_req_ready while busy", bad_rdy, 0);
      check("bp response held cycles bad", bad_resp, 0);
      lsu_resp_ready = 1'b1;
      #1;
      check("bp lsu_resp_valid at hs", lsu_resp_valid3, 1'b1);
      check("bp ifu_req_ready at hs", ifu_req_ready3, 1'b0);
      @(negedge clk);
      #1;
      check("bp ifu_req_ready after hs", ifu_req_ready3, 1'b1);
      check("bp lsu_resp_valid after hs", lsu_resp_valid3, 1'b0);

      // Reset during the second ACCESS cycle.
      @(negedge clk);
      do_reset();
      ifu_req_valid = 1'b1;
      ifu_req_addr  = 32'h0000_0080;
      #1;
      check("rstmid grant", ifu_req_ready3, 1'b1);
      @(negedge clk);
      ifu_req_valid = 1'b0;
      #1;
      check("rstmid access1 mem_valid", mem_valid3, 1'b1);
      @(negedge clk);
      rst           = 1'b1;
      ifu_req_valid = 1'b1;
      ifu_req_addr  = 32'h0000_0090;
      #1;
      check("rstmid mem_valid during rst", mem_valid3, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rstmid mem_valid after", mem_valid3, 1'b0);
      check("rstmid resp_valid after", ifu_resp_valid3, 1'b0);
      check("rstmid new grant", ifu_req_ready3, 1'b1);
      @(negedge clk);
      ifu_req_valid = 1'b0;
      #1;
      check("rstmid new access", mem_valid3, 1'b1);
      check("rstmid new addr", mem_raddr3, 32'h0000_0090);

      // Request inputs change after the handshake; LATENCY=3 store.
      @(negedge clk);
      do_reset();
      lsu_req_valid = 1'b1;
      lsu_req_wen   = 1'b1;
      lsu_req_addr  = 32'h8000_1000;
      lsu_req_wdata = 32'hDEAD_BEEF;
      lsu_req_wmask = 8'h0F;
      #1;
      check("latch grant", lsu_req_ready3, 1'b1);
      @(negedge clk);
      bad_mem = 0;
      for (int i = 0; i < 3; i++) begin
         lsu_req_wen   = 1'($urandom_range(0, 1));
         lsu_req_addr  = $urandom;
         lsu_req_wdata = $urandom;
         lsu_req_wmask = 8'($urandom);
         #1;
         if (!mem_valid3 || !mem_wen3 || mem_raddr3 != 32'h8000_1000 ||
             mem_waddr3 != 32'h8000_1000 || mem_wdata3 != 32'hDEAD_BEEF ||
             mem_wmask3 != 8'h0F || lsu_req_ready3)
            bad_mem++;
         @(negedge clk);
      end
      lsu_req_valid = 1'b0;
      check("latch access cycles bad", bad_mem, 0);
      #1;
      check("latch lsu_resp_valid", lsu_resp_valid3, 1'b1);
      check("latch lsu_resp_data", lsu_resp_data3, 32'h0);
      check("latch mem_valid in resp", mem_valid3, 1'b0);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
